// File: rtl/scancode_mapper.sv
// Maps PS/2 set-2 scancodes to a character-ROM glyph address and an RGB colour,
// tracking break/extended prefixes with an abandon timeout.
module scancode_mapper #(
    parameter int ADDR_W      = 6,
    parameter int STRIDE_LOG2 = 4,
    parameter int COLOR_MODE  = 0,
    parameter int TO_W        = 20
) (
    input  logic              vga_clk,
    input  logic              reset,
    input  logic              flag,
    input  logic [7:0]        scancode,
    output logic [ADDR_W-1:0] start_address_out,
    output logic              char_enable,
    output logic [2:0]        RGB,
    output logic              key_valid,
    output logic              timeout
);

    typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

    // The abandon fires on the edge that would bring the counter to all-ones,
    // giving 2^TO_W-1 waiting cycles after the prefix was accepted.
    localparam logic [TO_W-1:0] TO_LAST = ~TO_W'(1);

    state_t              r_state;
    logic [TO_W-1:0]     r_count;
    logic                r_flag_q;
    logic [1:0]          r_idx;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_char_en;
    logic [2:0]          r_rgb;
    logic                r_key_valid;
    logic                r_timeout;

    logic                w_strobe;
    logic                w_char_hit;
    logic [1:0]          w_char_idx;
    logic [2:0]          w_rgb_make;

    assign w_strobe = flag & ~r_flag_q;

    always_comb begin
        w_char_hit = 1'b1;
        w_char_idx = 2'd0;
        case (scancode)
            8'h2B:   w_char_idx = 2'd0;
            8'h15:   w_char_idx = 2'd1;
            8'h33:   w_char_idx = 2'd2;
            8'h22:   w_char_idx = 2'd3;
            default: w_char_hit = 1'b0;
        endcase
    end

    // Unrecognised codes fall through to the current colour, so the make path can assign unconditionally.
    always_comb begin
        w_rgb_make = r_rgb;
        case (scancode)
            8'h2D:   w_rgb_make = (COLOR_MODE == 1) ? (r_rgb ^ 3'b100) : 3'b100;
            8'h34:   w_rgb_make = (COLOR_MODE == 1) ? (r_rgb ^ 3'b010) : 3'b010;
            8'h32:   w_rgb_make = (COLOR_MODE == 1) ? (r_rgb ^ 3'b001) : 3'b001;
            8'h44:   w_rgb_make = 3'b000;
            8'h23:   w_rgb_make = 3'b111;
            default: w_rgb_make = r_rgb;
        endcase
    end

    always_ff @(posedge vga_clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_flag_q    <= 1'b0;
            r_idx       <= 2'd0;
            r_addr      <= '0;
            r_char_en   <= 1'b0;
            r_rgb       <= 3'b000;
            r_key_valid <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_flag_q    <= flag;
            r_key_valid <= 1'b0;
            r_timeout   <= 1'b0;
            if (w_strobe) begin
                r_count <= '0;
                case (r_state)
                    IDLE: begin
                        if (scancode == 8'hF0) begin
                            r_state <= BRK;
                        end else if (scancode == 8'hE0) begin
                            r_state <= EXT;
                        end else begin
                            r_rgb <= w_rgb_make;
                            if (w_char_hit) begin
                                r_idx       <= w_char_idx;
                                r_addr      <= ADDR_W'(w_char_idx) << STRIDE_LOG2;
                                r_char_en   <= 1'b1;
                                r_key_valid <= 1'b1;
                            end
                        end
                    end
                    BRK: begin
                        // Only releasing the key currently on screen blanks it.
                        if (w_char_hit && (w_char_idx == r_idx) && r_char_en)
                            r_char_en <= 1'b0;
                        r_state <= IDLE;
                    end
                    EXT: begin
                        r_state <= (scancode == 8'hF0) ? EXT_BRK : IDLE;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end else if (r_state == IDLE) begin
                r_count <= '0;
            end else if (r_count == TO_LAST) begin
                r_state   <= IDLE;
                r_count   <= '0;
                r_timeout <= 1'b1;
            end else begin
                r_count <= r_count + TO_W'(1);
            end
        end
    end

    assign start_address_out = r_addr;
    assign char_enable       = r_char_en;
    assign RGB               = r_rgb;
    assign key_valid         = r_key_valid;
    assign timeout           = r_timeout;

endmodule

// File: tb/tb_scancode_mapper.sv
// Randomised bench for scancode_mapper: a prefix/lookup-table model is compared
// against two instances (direct and toggle colour modes) every cycle.
module tb_scancode_mapper;

    localparam int TO_W     = 4;
    localparam int TO_LIMIT = (1 << TO_W) - 1;
    localparam int NONE = 0, PBRK = 1, PEXT = 2, PEXTBRK = 3;

    logic       clk;
    logic       rst_n;
    logic       flag;
    logic [7:0] scancode;

    logic [5:0] addr0, addr1;
    logic       en0, en1, kv0, kv1, to0, to1;
    logic [2:0] rgb0, rgb1;

    int errors = 0;
    int checks = 0;
    int kvCount0 = 0;
    int toCount0 = 0;

    scancode_mapper #(.ADDR_W(6), .STRIDE_LOG2(4), .COLOR_MODE(0), .TO_W(TO_W)) dut0 (
        .vga_clk(clk), .reset(rst_n), .flag(flag), .scancode(scancode),
        .start_address_out(addr0), .char_enable(en0), .RGB(rgb0),
        .key_valid(kv0), .timeout(to0));

    scancode_mapper #(.ADDR_W(6), .STRIDE_LOG2(4), .COLOR_MODE(1), .TO_W(TO_W)) dut1 (
        .vga_clk(clk), .reset(rst_n), .flag(flag), .scancode(scancode),
        .start_address_out(addr1), .char_enable(en1), .RGB(rgb1),
        .key_valid(kv1), .timeout(to1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] charCodes [4] = '{8'h2B, 8'h15, 8'h33, 8'h22};
    logic [7:0] colCodes  [5] = '{8'h2D, 8'h34, 8'h32, 8'h44, 8'h23};
    logic [2:0] colBits   [5] = '{3'b100, 3'b010, 3'b001, 3'b000, 3'b111};

    int         mPending  = NONE;
    int         mWait     = 0;
    logic       mPrevFlag = 1'b0;
    int         mIdx      = 0;
    logic       mEn       = 1'b0;
    logic [2:0] mRgb0     = 3'b000;
    logic [2:0] mRgb1     = 3'b000;
    logic       mKv       = 1'b0;
    logic       mTo       = 1'b0;

    function automatic int charIdx(input logic [7:0] b);
        for (int i = 0; i < 4; i++) if (charCodes[i] == b) return i;
        return -1;
    endfunction

    function automatic int colIdx(input logic [7:0] b);
        for (int i = 0; i < 5; i++) if (colCodes[i] == b) return i;
        return -1;
    endfunction

    task automatic modelMake(input logic [7:0] b);
        int ci, ki;
        ci = charIdx(b);
        ki = colIdx(b);
        if (ci >= 0) begin
            mIdx = ci;
            mEn  = 1'b1;
            mKv  = 1'b1;
        end
        if (ki >= 0) begin
            mRgb0 = colBits[ki];
            mRgb1 = (ki < 3) ? (mRgb1 ^ colBits[ki]) : colBits[ki];
        end
    endtask

    task automatic modelByte(input logic [7:0] b);
        mWait = 0;
        if (mPending == NONE) begin
            if (b == 8'hF0)      mPending = PBRK;
            else if (b == 8'hE0) mPending = PEXT;
            else                 modelMake(b);
        end else if (mPending == PBRK) begin
            if (charIdx(b) >= 0 && charIdx(b) == mIdx && mEn) mEn = 1'b0;
            mPending = NONE;
        end else if (mPending == PEXT) begin
            mPending = (b == 8'hF0) ? PEXTBRK : NONE;
        end else begin
            mPending = NONE;
        end
    endtask

    // Reference model: a new byte arrives on each rising flag; a prefix waiting TO_LIMIT cycles is dropped.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mPending = NONE; mWait = 0; mPrevFlag = 1'b0; mIdx = 0; mEn = 1'b0;
            mRgb0 = 3'b000; mRgb1 = 3'b000; mKv = 1'b0; mTo = 1'b0;
        end else begin
            mKv = 1'b0;
            mTo = 1'b0;
            if (flag && !mPrevFlag) begin
                modelByte(scancode);
            end else if (mPending != NONE) begin
                mWait++;
                if (mWait == TO_LIMIT) begin
                    mPending = NONE;
                    mWait    = 0;
                    mTo      = 1'b1;
                end
            end
            mPrevFlag = flag;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model, just after the active edge.
    always @(posedge clk) begin
        #1;
        checkOutput("addr0", 32'(addr0), 32'(mIdx) << 4);
        checkOutput("addr1", 32'(addr1), 32'(mIdx) << 4);
        checkOutput("en0", 32'(en0), 32'(mEn));
        checkOutput("en1", 32'(en1), 32'(mEn));
        checkOutput("rgb0", 32'(rgb0), 32'(mRgb0));
        checkOutput("rgb1", 32'(rgb1), 32'(mRgb1));
        checkOutput("kv0", 32'(kv0), 32'(mKv));
        checkOutput("kv1", 32'(kv1), 32'(mKv));
        checkOutput("to0", 32'(to0), 32'(mTo));
        checkOutput("to1", 32'(to1), 32'(mTo));
        if (kv0) kvCount0++;
        if (to0) toCount0++;
    end

    task automatic applyStimulus(input logic [7:0] b, input int hold, input int gap);
        @(negedge clk);
        flag     = 1'b1;
        scancode = b;
        repeat (hold) @(negedge clk);
        flag = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    logic [7:0] pool [11] = '{8'h2B, 8'h15, 8'h33, 8'h22, 8'h2D, 8'h34,
                              8'h32, 8'h44, 8'h23, 8'hF0, 8'hE0};

    initial begin
        int kvBase, toBase, r;
        logic [7:0] b;
        rst_n = 1'b0; flag = 1'b0; scancode = 8'h00;
        #3;
        checkOutput("reset_addr", 32'(addr0), 32'h0);
        checkOutput("reset_en", 32'(en0), 32'h0);
        checkOutput("reset_rgb", 32'(rgb1), 32'h0);
        checkOutput("reset_pulses", 32'({kv0, to0}), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        kvBase = kvCount0;
        applyStimulus(8'h15, 10, 2);
        checkOutput("make_q_addr", 32'(addr0), 32'h10);
        checkOutput("make_q_en", 32'(en0), 32'h1);
        checkOutput("held_flag_one_pulse", 32'(kvCount0 - kvBase), 32'h1);

        applyStimulus(8'hF0, 1, 1);
        applyStimulus(8'h2B, 1, 1);
        checkOutput("other_break_keeps_en", 32'(en0), 32'h1);
        applyStimulus(8'hF0, 1, 1);
        applyStimulus(8'h15, 1, 1);
        checkOutput("own_break_clears_en", 32'(en0), 32'h0);
        checkOutput("break_keeps_addr", 32'(addr0), 32'h10);

        applyStimulus(8'h2D, 1, 1);
        checkOutput("direct_red", 32'(rgb0), 32'h4);
        applyStimulus(8'h23, 1, 1);
        checkOutput("direct_all", 32'(rgb0), 32'h7);
        applyStimulus(8'h44, 1, 1);
        checkOutput("toggle_off", 32'(rgb1), 32'h0);
        applyStimulus(8'h2D, 1, 1);
        applyStimulus(8'h34, 1, 1);
        applyStimulus(8'h2D, 1, 1);
        checkOutput("toggle_seq", 32'(rgb1), 32'h2);
        checkOutput("direct_after_seq", 32'(rgb0), 32'h4);

        applyStimulus(8'hE0, 1, 1);
        applyStimulus(8'h2B, 1, 1);
        checkOutput("ext_ignored_en", 32'(en0), 32'h0);
        checkOutput("ext_ignored_addr", 32'(addr0), 32'h10);
        applyStimulus(8'h2B, 1, 1);
        checkOutput("after_ext_make_en", 32'(en0), 32'h1);
        checkOutput("after_ext_make_addr", 32'(addr0), 32'h0);

        toBase = toCount0;
        applyStimulus(8'hF0, 1, 20);
        checkOutput("timeout_one_pulse", 32'(toCount0 - toBase), 32'h1);
        applyStimulus(8'h22, 1, 1);
        checkOutput("post_timeout_addr", 32'(addr0), 32'h30);
        checkOutput("post_timeout_en", 32'(en0), 32'h1);

        applyStimulus(8'h15, 1, 1);
        applyStimulus(8'hF0, 1, 2);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_addr", 32'(addr0), 32'h0);
        checkOutput("async_reset_en", 32'(en0), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(8'h15, 1, 1);
        checkOutput("prefix_discarded_en", 32'(en0), 32'h1);

        @(negedge clk);
        rst_n    = 1'b0;
        flag     = 1'b1;
        scancode = 8'h33;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        flag = 1'b0;
        checkOutput("flag_high_at_release_addr", 32'(addr0), 32'h20);
        checkOutput("flag_high_at_release_en", 32'(en0), 32'h1);

        for (int n = 0; n < 2500; n++) begin
            r = $urandom_range(0, 13);
            if (r < 11)       b = pool[r];
            else if (r == 11) b = 8'hF0;
            else              b = 8'($urandom);
            applyStimulus(b, $urandom_range(1, 3), $urandom_range(1, 18));
            if ($urandom_range(0, 99) == 0) begin
                #($urandom_range(1, 8)) rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
